// File: rtl/store_align_pkg.sv
// rtl/store_align_pkg.sv - shared types and constants for the store aligner
// Purpose: access-size encodings, FSM state enum and lane mask constants
//          used by store_align and lane_shift.
// Ports:   none (package).
package store_align_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_WORD    = 2'b10,
      SIZE_ILLEGAL = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BEAT0 = 2'b01,
      BEAT1 = 2'b10,
      ERR   = 2'b11
   } state_e;

   localparam logic [3:0] MASK_BYTE = 4'b0001;
   localparam logic [3:0] MASK_HALF = 4'b0011;
   localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/store_align_lane_shift.sv
// rtl/store_align_lane_shift.sv - places store data and byte enables on lanes
// Purpose: zero the register bits above the access size, then shift data and
//          byte mask up by the address offset into a two-word window.
// Ports:   data - register value      size - access size encoding
//          off  - byte offset [1:0]   d    - 64-bit lane-placed data
//          b    - 8-bit lane-placed byte enables (b[7:4] nonzero = crossing)
module lane_shift
   import store_align_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   output logic [63:0] d,
   output logic [7:0]  b
);

   logic [31:0] data_m;
   logic [3:0]  mask;

   // Illegal size falls through as a word; the top level rejects it anyway.
   always_comb begin
      mask   = MASK_WORD;
      data_m = data;
      case (size_e'(size))
         SIZE_BYTE: begin
            mask   = MASK_BYTE;
            data_m = {24'b0, data[7:0]};
         end
         SIZE_HALF: begin
            mask   = MASK_HALF;
            data_m = {16'b0, data[15:0]};
         end
         default: ;
      endcase
   end

   assign d = {32'b0, data_m} << {off, 3'b000};
   assign b = {4'b0, mask} << off;

endmodule

// File: rtl/store_align.sv
// rtl/store_align.sv - turns byte/half/word stores into word-aligned write beats
// Purpose: accepts one store at a time, emits one registered write beat, or two
//          for a store that crosses a word boundary when STORE_ALIGN_SPLIT_EN
//          is defined. Without STORE_ALIGN_SPLIT_EN crossing stores are
//          rejected like an illegal size (err pulse, no beat).
// Ports:   clk, rst_n (async, active low)
//          req_valid/req_ready, req_addr, req_data, req_size - store request
//          mem_valid/mem_ready, mem_addr, mem_wdata, mem_be  - write beat
//          err - one-cycle pulse for a rejected request
module store_align
   import store_align_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_data,
   input  logic [1:0]      req_size,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_be,
   output logic            err
);

   state_e            state, state_next;
   logic              valid_n, err_n;
   logic [XLEN-1:0]   addr_n, wdata_n;
   logic [3:0]        be_n;
   logic [63:0]       d;
   logic [7:0]        b;
   logic              reject;

   lane_shift u_lane_shift (
      .data (req_data),
      .size (req_size),
      .off  (req_addr[1:0]),
      .d    (d),
      .b    (b)
   );

   assign req_ready = (state == IDLE);

`ifdef STORE_ALIGN_SPLIT_EN
   // Upper half of the window, parked until beat0 is taken; a nonzero
   // enable means a second beat is owed.
   logic [31:0] hi_wdata, hi_wdata_n;
   logic [3:0]  hi_be, hi_be_n;

   assign reject = (req_size == SIZE_ILLEGAL);
`else
   logic unused_hi;

   assign unused_hi = ^d[63:32];
   assign reject    = (req_size == SIZE_ILLEGAL) || (|b[7:4]);
`endif

   always_comb begin
      state_next = state;
      valid_n    = mem_valid;
      addr_n     = mem_addr;
      wdata_n    = mem_wdata;
      be_n       = mem_be;
      err_n      = 1'b0;
`ifdef STORE_ALIGN_SPLIT_EN
      hi_wdata_n = hi_wdata;
      hi_be_n    = hi_be;
`endif
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (reject) begin
                  state_next = ERR;
                  err_n      = 1'b1;
               end else begin
                  state_next = BEAT0;
                  valid_n    = 1'b1;
                  addr_n     = {req_addr[XLEN-1:2], 2'b00};
                  wdata_n    = d[31:0];
                  be_n       = b[3:0];
`ifdef STORE_ALIGN_SPLIT_EN
                  hi_wdata_n = d[63:32];
                  hi_be_n    = b[7:4];
`endif
               end
            end
         end
         BEAT0: begin
            if (mem_ready) begin
`ifdef STORE_ALIGN_SPLIT_EN
               if (|hi_be) begin
                  state_next = BEAT1;
                  addr_n     = mem_addr + XLEN'(4);
                  wdata_n    = hi_wdata;
                  be_n       = hi_be;
               end else begin
                  state_next = IDLE;
                  valid_n    = 1'b0;
               end
`else
               state_next = IDLE;
               valid_n    = 1'b0;
`endif
            end
         end
`ifdef STORE_ALIGN_SPLIT_EN
         BEAT1: begin
            if (mem_ready) begin
               state_next = IDLE;
               valid_n    = 1'b0;
            end
         end
`endif
         ERR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            valid_n    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         err       <= 1'b0;
`ifdef STORE_ALIGN_SPLIT_EN
         hi_wdata  <= '0;
         hi_be     <= '0;
`endif
      end else begin
         state     <= state_next;
         mem_valid <= valid_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         mem_be    <= be_n;
         err       <= err_n;
`ifdef STORE_ALIGN_SPLIT_EN
         hi_wdata  <= hi_wdata_n;
         hi_be     <= hi_be_n;
`endif
      end
   end

endmodule

// File: tb/tb_store_align.sv
// tb/tb_store_align.sv - self-checking bench for store_align
module tb_store_align;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [1:0]  req_size = '0;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        err;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] got_addr  [0:1];
   logic [31:0] got_wdata [0:1];
   logic [3:0]  got_be    [0:1];
   int          got_n;
   int          got_err;

   store_align #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_size  (req_size),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Issue one store (entered and left at 1ns after a rising edge with the
   // DUT idle), collect its beats/err pulses, and compare against a
   // byte-by-byte model. stall_n >= 0 holds mem_ready low for that many
   // valid cycles per beat; stall_n < 0 randomizes mem_ready.
   task automatic run_req(input logic [31:0] a, input logic [31:0] dv,
                          input logic [1:0] s, input int stall_n);
      logic [31:0] e_addr [0:1];
      logic [31:0] e_wdata [0:1];
      logic [3:0]  e_be [0:1];
      int          e_n, n, off, lane, cnt;
      bit          e_err, done, prev_stall, rdy;
      logic [31:0] p_addr, p_wdata;
      logic [3:0]  p_be;

      off = int'(a[1:0]);
      n   = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
      e_addr[0]  = {a[31:2], 2'b00};
      e_addr[1]  = e_addr[0] + 32'd4;
      e_wdata[0] = '0; e_wdata[1] = '0;
      e_be[0]    = '0; e_be[1]    = '0;
      for (int k = 0; k < n; k++) begin
         lane = off + k;
         e_wdata[lane / 4][8 * (lane % 4) +: 8] = dv[8 * k +: 8];
         e_be[lane / 4][lane % 4] = 1'b1;
      end
      e_n   = (off + n > 4) ? 2 : 1;
      e_err = (s == 2'b11);
`ifndef STORE_ALIGN_SPLIT_EN
      if (e_n == 2) e_err = 1'b1;
`endif
      if (e_err) e_n = 0;

      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL req_ready_idle: got %b exp 1", req_ready);
      end
      req_valid = 1'b1; req_addr = a; req_data = dv; req_size = s;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_data  = $urandom;
      req_size  = 2'($urandom);

      got_n = 0; got_err = 0; cnt = 0; prev_stall = 1'b0; done = 1'b0;
      p_addr = '0; p_wdata = '0; p_be = '0;
      for (int cyc = 0; cyc < 24 && !done; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         if (cyc == 0) begin
            vectors++;
            if (mem_valid !== (e_n > 0) || err !== e_err) begin
               miscompares++;
               $display("FAIL latency: got valid=%b err=%b exp valid=%b err=%b",
                        mem_valid, err, (e_n > 0), e_err);
            end
         end
         if (err === 1'b1) got_err++;
         if (mem_valid === 1'b1) begin
            vectors++;
            if (req_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL req_ready_busy: got %b exp 0", req_ready);
            end
            if (prev_stall) begin
               vectors++;
               if (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_be !== p_be) begin
                  miscompares++;
                  $display("FAIL hold: got %h/%h/%b exp %h/%h/%b",
                           mem_addr, mem_wdata, mem_be, p_addr, p_wdata, p_be);
               end
            end
            rdy = (stall_n >= 0) ? (cnt >= stall_n) : ($urandom_range(0, 2) != 0);
            mem_ready = rdy;
            if (rdy) begin
               if (got_n < 2) begin
                  got_addr[got_n]  = mem_addr;
                  got_wdata[got_n] = mem_wdata;
                  got_be[got_n]    = mem_be;
               end
               got_n++;
               cnt = 0;
               prev_stall = 1'b0;
            end else begin
               cnt++;
               prev_stall = 1'b1;
               p_addr = mem_addr; p_wdata = mem_wdata; p_be = mem_be;
            end
         end else begin
            if (prev_stall) begin
               vectors++;
               miscompares++;
               $display("FAIL hold_valid: got 0 exp 1");
               prev_stall = 1'b0;
            end
            mem_ready = 1'($urandom);
            if (err !== 1'b1 && cyc > 0) done = 1'b1;
         end
      end
      mem_ready = 1'b0;

      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL timeout: got busy exp idle within 24 cycles");
      end
      vectors++;
      if (got_n != e_n || got_err != int'(e_err)) begin
         miscompares++;
         $display("FAIL beat_count a=%h s=%b: got beats=%0d err=%0d exp beats=%0d err=%0d",
                  a, s, got_n, got_err, e_n, e_err);
      end else begin
         for (int i = 0; i < e_n; i++) begin
            vectors++;
            if (got_addr[i] !== e_addr[i] || got_wdata[i] !== e_wdata[i] || got_be[i] !== e_be[i]) begin
               miscompares++;
               $display("FAIL beat%0d a=%h d=%h s=%b: got %h/%h/%b exp %h/%h/%b", i, a, dv, s,
                        got_addr[i], got_wdata[i], got_be[i], e_addr[i], e_wdata[i], e_be[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
          mem_be !== 4'h0 || err !== 1'b0 || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset: got v=%b a=%h d=%h be=%b err=%b rdy=%b exp 0/0/0/0/0/1",
                  mem_valid, mem_addr, mem_wdata, mem_be, err, req_ready);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_req(32'h0000_1003, 32'hAABB_CCDD, 2'b00, 0);
      vectors++;
      if (got_n != 1 || got_addr[0] !== 32'h0000_1000 || got_wdata[0] !== 32'hDD00_0000 ||
          got_be[0] !== 4'b1000) begin
         miscompares++;
         $display("FAIL byte_1003: got n=%0d %h/%h/%b exp 1 00001000/dd000000/1000",
                  got_n, got_addr[0], got_wdata[0], got_be[0]);
      end
      run_req(32'h0000_2002, 32'h0000_1234, 2'b01, 0);
      vectors++;
      if (got_n != 1 || got_addr[0] !== 32'h0000_2000 || got_wdata[0] !== 32'h1234_0000 ||
          got_be[0] !== 4'b1100) begin
         miscompares++;
         $display("FAIL half_2002: got n=%0d %h/%h/%b exp 1 00002000/12340000/1100",
                  got_n, got_addr[0], got_wdata[0], got_be[0]);
      end
      run_req(32'h0000_3001, 32'h1122_3344, 2'b10, 0);
      vectors++;
`ifdef STORE_ALIGN_SPLIT_EN
      if (got_n != 2 || got_addr[0] !== 32'h0000_3000 || got_wdata[0] !== 32'h2233_4400 ||
          got_be[0] !== 4'b1110 || got_addr[1] !== 32'h0000_3004 ||
          got_wdata[1] !== 32'h0000_0011 || got_be[1] !== 4'b0001) begin
         miscompares++;
         $display("FAIL word_3001: got n=%0d %h/%h/%b %h/%h/%b exp 2 split beats",
                  got_n, got_addr[0], got_wdata[0], got_be[0], got_addr[1], got_wdata[1], got_be[1]);
      end
`else
      if (got_n != 0 || got_err != 1) begin
         miscompares++;
         $display("FAIL word_3001_reject: got beats=%0d err=%0d exp 0/1", got_n, got_err);
      end
`endif
   endtask

   task automatic test_stall();
      run_req(32'h0000_0040, 32'hCAFE_F00D, 2'b10, 3);
      run_req(32'h0000_0045, 32'h0000_00A5, 2'b00, 3);
   endtask

   task automatic test_illegal();
      run_req(32'h0000_0100, 32'h5555_5555, 2'b11, 0);
      vectors++;
      if (got_err != 1 || got_n != 0) begin
         miscompares++;
         $display("FAIL illegal_size: got err=%0d beats=%0d exp 1/0", got_err, got_n);
      end
      run_req(32'h0000_0203, 32'h0000_BEEF, 2'b01, 0);
   endtask

   task automatic test_wrap_reset();
      mem_ready = 1'b1;
`ifdef STORE_ALIGN_SPLIT_EN
      req_valid = 1'b1; req_addr = 32'hFFFF_FFFE; req_data = 32'h1122_3344; req_size = 2'b10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      vectors++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'hFFFF_FFFC || mem_wdata !== 32'h3344_0000 ||
          mem_be !== 4'b1100) begin
         miscompares++;
         $display("FAIL wrap_beat0: got %b %h/%h/%b exp 1 fffffffc/33440000/1100",
                  mem_valid, mem_addr, mem_wdata, mem_be);
      end
      @(posedge clk); #1;
      vectors++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0000 || mem_wdata !== 32'h0000_1122 ||
          mem_be !== 4'b0011) begin
         miscompares++;
         $display("FAIL wrap_beat1: got %b %h/%h/%b exp 1 00000000/00001122/0011",
                  mem_valid, mem_addr, mem_wdata, mem_be);
      end
`else
      mem_ready = 1'b0;
      req_valid = 1'b1; req_addr = 32'h0000_0010; req_data = 32'h7777_8888; req_size = 2'b10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      vectors++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0010 || mem_wdata !== 32'h7777_8888) begin
         miscompares++;
         $display("FAIL pre_reset_beat: got %b %h/%h exp 1 00000010/77778888",
                  mem_valid, mem_addr, mem_wdata);
      end
`endif
      mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (mem_valid !== 1'b0 || req_ready !== 1'b1 || mem_be !== 4'h0 || mem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL async_reset: got v=%b rdy=%b be=%b a=%h exp 0/1/0000/00000000",
                  mem_valid, req_ready, mem_be, mem_addr);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_idle: got v=%b rdy=%b exp 0/1", mem_valid, req_ready);
         end
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      run_req(32'h0000_0500, 32'h0102_0304, 2'b10, 0);
      run_req(32'h0000_0601, 32'h0000_00FF, 2'b00, 0);
      run_req(32'h0000_0702, 32'h0000_ABCD, 2'b01, 0);
      run_req(32'h0000_0803, 32'h89AB_CDEF, 2'b10, 0);
      run_req(32'h0000_0907, 32'h0000_4321, 2'b01, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         run_req($urandom, $urandom, 2'($urandom_range(0, 3)), -1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_illegal();
      test_wrap_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/store_align.md
STORE_ALIGN -- requirements
Module: store_align

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, store request present.
REQ-005 SHALL have port req_ready, output, 1, block accepts a request.
REQ-006 SHALL have port req_addr, input, 32, byte address.
REQ-007 SHALL have port req_data, input, 32, register value; low bytes used for narrow stores.
REQ-008 SHALL have port req_size, input, 2, encoded as 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port mem_valid, output, 1, write beat present.
REQ-010 SHALL have port mem_ready, input, 1, memory accepts the beat.
REQ-011 SHALL have port mem_addr, output, 32, word-aligned address with bits [1:0] = 00.
REQ-012 SHALL have port mem_wdata, output, 32, lane-placed write data.
REQ-013 SHALL have port mem_be, output, 4, byte enables; bit i qualifies lane i.
REQ-014 SHALL have port err, output, 1, one-cycle pulse reporting a rejected request.

Function
REQ-015 SHALL implement FSM states IDLE, BEAT0, BEAT1 and ERR.
REQ-016 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-017 SHALL register all mem_* outputs and err; mem_valid rises in the cycle after acceptance (latency 1).
REQ-018 SHALL compute off = req_addr[1:0] and mask = 0001/0011/1111 for byte/half/word.
REQ-019 SHALL form D = {32'b0, req_data} << (8*off) and B = {4'b0, mask} << off, both 64/8 bits wide.
REQ-020 SHALL zero req_data bits above the access size before shifting, so unused lanes are 0.
REQ-021 SHALL drive beat0 as mem_addr = {req_addr[31:2], 00}, mem_wdata = D[31:0] and mem_be = B[3:0].
REQ-022 SHALL treat a request as crossing when B[7:4] != 0 (half at off 3, or word at off 1, 2 or 3).
REQ-023 SHALL, for a crossing request, drive beat1 as mem_addr = beat0 addr + 4 (mod 2^32), mem_wdata = D[63:32] and mem_be = B[7:4].
REQ-024 SHALL hold mem_addr, mem_wdata and mem_be stable while mem_valid && !mem_ready.
REQ-025 SHALL take the following transitions: BEAT0 with mem_ready goes to BEAT1 if crossing, else IDLE; BEAT1 with mem_ready goes to IDLE.
REQ-026 SHALL drop mem_valid in the cycle after the final beat is accepted; back-to-back requests therefore leave a one-cycle gap.
REQ-027 SHALL treat req_size = 11 as illegal: go IDLE -> ERR, err = 1 for exactly one cycle, mem_valid = 0, then return to IDLE.
REQ-028 SHALL ignore req_addr, req_data and req_size outside the acceptance cycle.

Reset
REQ-029 SHALL, while rst_n = 0, set state = IDLE, mem_valid = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0 and err = 0; req_ready = 1.
REQ-030 SHALL, on reset asserted mid-operation, discard the pending beat(s) immediately with no further beat after release.

Configuration
REQ-031 SHALL, with STORE_ALIGN_SPLIT_EN defined, split crossing requests into two beats per REQ-023.
REQ-032 SHALL, without STORE_ALIGN_SPLIT_EN, handle crossing requests as illegal per REQ-027 (err pulse, no beat); BEAT1 logic is absent.

Structure
REQ-033 SHALL place in package store_align_pkg: the size encodings, the state enum, and the byte/half/word mask constants.
REQ-034 SHALL implement the shift of REQ-019 in one combinational sub-module lane_shift (inputs data, size, off; outputs D, B).

Verification
REQ-035 SHALL check: byte store, addr 0x1003, data 0xAABBCCDD -> one beat, addr 0x1000, wdata 0xDD000000, be 1000.
REQ-036 SHALL check: half store, addr 0x2002, data 0x1234 -> one beat, addr 0x2000, wdata 0x12340000, be 1100.
REQ-037 SHALL check (SPLIT_EN): word store, addr 0x3001, data 0x11223344 -> beat0 addr 0x3000, wdata 0x22334400, be 1110; beat1 addr 0x3004, wdata 0x00000011, be 0001.
REQ-038 SHALL check: mem_ready held low for 3 cycles during beat0 -> payload stable; req_ready = 0 throughout.
REQ-039 SHALL check: req_size 11, or crossing without SPLIT_EN -> err high for exactly 1 cycle, mem_valid never high.
REQ-040 SHALL check: word at 0xFFFFFFFE with SPLIT_EN -> beat1 addr wraps to 0x00000000; rst_n pulsed low during beat1 -> mem_valid = 0 immediately, FSM in IDLE.
